vga_fb_sram_arbiter: RTL

- Parametrised framebuffer engine between the CPU write path and a single-port asynchronous SRAM holding a scaled framebuffer.
- Buffers CPU pixel writes in a FIFO and prefetches display pixels from SRAM with fixed priority over writes.
- Drains writes anytime or only during vertical blanking, selected by WR_MODE.
- Expands RGB332 or RGB565 pixels to 4:4:4 VGA outputs; timing positions come from the existing vga timing generator.

---
 rtl/vga_fb_sram_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_sram_arbiter
//  Purpose  : Framebuffer engine sharing one asynchronous single-port SRAM
//             between display prefetch (fixed priority) and a buffered CPU
//             write path. It also expands RGB332/RGB565 pixels to 4:4:4 VGA.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_sram_arbiter #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int SCALE_LOG2 = 1,
    parameter int PIX_W      = 8,
    parameter int AW         = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int WR_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_en,
    input  logic [X_W-1:0]                hpos,
    input  logic [Y_W-1:0]                vpos,
    input  logic                          display_on,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [PIX_W-1:0]              wr_data,
    output logic [AW-1:0]                 sram_addr,
    output logic                          sram_we_n,
    output logic [PIX_W-1:0]              sram_wdata,
    output logic                          sram_wdata_oe,
    input  logic [PIX_W-1:0]              sram_rdata,
    output logic [3:0]                    vga_r,
    output logic [3:0]                    vga_g,
    output logic [3:0]                    vga_b,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start
);

    localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int c_SUB_MASK   = (1 << SCALE_LOG2) - 1;
    localparam int c_LINE_WORDS = H_ACTIVE >> SCALE_LOG2;

    // ------------------------------------------------------------------
    // Next screen position and read-slot detection
    // ------------------------------------------------------------------
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [X_W-1:0]   w_nh;
    logic [Y_W-1:0]   w_nv;
    logic             w_read_slot;
    logic [AW-1:0]    w_rd_addr;

    // Position the timing generator moves to on this pix_en
    always_comb begin
        w_h_wrap = (hpos == X_W'(H_TOTAL - 1));
        w_v_wrap = (vpos == Y_W'(V_TOTAL - 1));
        w_nh     = w_h_wrap ? '0 : hpos + 1'b1;
        w_nv     = vpos;
        if (w_h_wrap) begin
            w_nv = w_v_wrap ? '0 : vpos + 1'b1;
        end
    end

    // A fetch is needed on the first screen column of each replicated group
    assign w_read_slot = pix_en
                       && (w_nh < X_W'(H_ACTIVE))
                       && (w_nv < Y_W'(V_ACTIVE))
                       && (((w_nh & X_W'(c_SUB_MASK)) == '0) || (w_nh == '0));

    assign w_rd_addr = AW'(w_nv >> SCALE_LOG2) * AW'(c_LINE_WORDS)
                     + AW'(w_nh >> SCALE_LOG2);

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [AW-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [PIX_W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W:0]  r_wptr;
    logic [c_PTR_W:0]  r_rptr;
    logic [c_PTR_W:0]  w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_issue;
    logic              w_vblank_ok;
    logic              r_wr_last;

    assign w_level    = r_wptr - r_rptr;
    assign w_full     = (w_level == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty    = (w_level == '0);
    assign wr_ready   = !w_full;
    assign fifo_level = w_level;
    assign w_push     = wr_valid && wr_ready;

    // Writes may use the bus only where display reads never need it, and
    // never in the cycle right after a write (data-bus turnaround)
    assign w_vblank_ok = (WR_MODE == 0) || (vpos >= Y_W'(V_ACTIVE));
    assign w_issue     = !w_read_slot && !w_empty && !r_wr_last && w_vblank_ok;

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[c_PTR_W-1:0]] <= wr_addr;
            r_fifo_data[r_wptr[c_PTR_W-1:0]] <= wr_data;
        end
    end

    // FIFO pointers; reset discards everything queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM bus (registered) and read data capture
    // ------------------------------------------------------------------
    logic [AW-1:0]     r_last_rd_addr;
    logic              r_rd_bus;
    logic [PIX_W-1:0]  r_fetch;
    logic              r_fetch_new;

    // Drive one bus cycle: display read, queued write, or park on last read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_addr      <= '0;
            sram_we_n      <= 1'b1;
            sram_wdata     <= '0;
            sram_wdata_oe  <= 1'b0;
            r_last_rd_addr <= '0;
            r_wr_last      <= 1'b0;
            r_rd_bus       <= 1'b0;
        end else begin
            r_wr_last     <= w_issue;
            r_rd_bus      <= w_read_slot;
            sram_we_n     <= !w_issue;
            sram_wdata_oe <= w_issue;
            if (w_read_slot) begin
                sram_addr      <= w_rd_addr;
                r_last_rd_addr <= w_rd_addr;
            end else if (w_issue) begin
                sram_addr  <= r_fifo_addr[r_rptr[c_PTR_W-1:0]];
                sram_wdata <= r_fifo_data[r_rptr[c_PTR_W-1:0]];
            end else begin
                sram_addr <= r_last_rd_addr;
            end
        end
    end

    // Capture read data at the end of the read bus cycle; flag it as fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch     <= '0;
            r_fetch_new <= 1'b0;
        end else if (r_rd_bus) begin
            r_fetch     <= sram_rdata;
            r_fetch_new <= 1'b1;
        end else if (pix_en) begin
            r_fetch_new <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display register, colour expansion and VGA outputs
    // ------------------------------------------------------------------
    logic [PIX_W-1:0]  r_disp;
    logic [PIX_W-1:0]  w_disp_next;
    logic [3:0]        w_r;
    logic [3:0]        w_g;
    logic [3:0]        w_b;

    assign w_disp_next = (pix_en && r_fetch_new) ? r_fetch : r_disp;

    generate
        if (PIX_W == 16) begin : g_rgb565
            assign w_r = w_disp_next[15:12];
            assign w_g = w_disp_next[10:7];
            assign w_b = w_disp_next[4:1];
        end else begin : g_rgb332
            assign w_r = {w_disp_next[7:5], |w_disp_next[7:5]};
            assign w_g = {w_disp_next[4:2], |w_disp_next[4:2]};
            assign w_b = {w_disp_next[1:0], |w_disp_next[1:0], w_disp_next[1]};
        end
    endgenerate

    // Hold the fetched pixel across its replicated columns and drive VGA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp      <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            r_disp      <= w_disp_next;
            vga_r       <= display_on ? w_r : 4'h0;
            vga_g       <= display_on ? w_g : 4'h0;
            vga_b       <= display_on ? w_b : 4'h0;
            frame_start <= pix_en && w_h_wrap && w_v_wrap;
        end
    end

endmodule
`default_nettype wire
